fir_array_ctrl: RTL
===================

// Module: fir_array_ctrl
// PURPOSE
//   Sequencer for the TAPS-stage systolic FIR array of signed PE cells. Loads the per-tap
//   coefficients serially, streams samples into the array under valid/ready handshake,
//   generates the array advance enable, tracks array latency and returns results
//   through a one-entry output register with backpressure. Flush drains in-flight results.
// PARAMETERS
//   W     32  sample/coefficient/result width, signed two's complement
//   TAPS   4  number of PE stages (coefficients), >= 2
//   LAT    4  array advances from sample on arr_x to its result on arr_y, 1..32
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        reset, asynchronous, active-high
//   cfg_start  in   1        pulse: begin coefficient load (honoured in IDLE only)
//   coef_in    in   W        coefficient beat
//   coef_valid in   1        coefficient beat valid
//   coef_ready out  1        high in LOAD
//   w_out      out  TAPS*W   coefficient bus; slice [i*W +: W] drives PE i
//   in_data    in   W        input sample
//   in_valid   in   1        sample valid
//   in_ready   out  1        sample accepted when in_valid & in_ready
//   flush      in   1        pulse: drain array (honoured in RUN only)
//   arr_x      out  W        sample to array stage 0 (zero during flush)
//   arr_en     out  1        array register advance enable
//   arr_y      in   W        result from last array stage
//   out_data   out  W        filtered result
//   out_valid  out  1        result valid; held until out_ready
//   out_ready  in   1        downstream accept
//   busy       out  1        state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; coefficient regs, w_out, vpipe, out_data, counters = 0;
//     coef_ready, in_ready, arr_en, out_valid, busy = 0; arr_x = 0.
//   States: IDLE -> LOAD on cfg_start; LOAD -> RUN after TAPS accepted beats;
//     RUN -> FLUSH on flush; FLUSH -> IDLE after LAT advances AND out_valid==0.
//   LOAD: beat k (0-based, coef_valid&coef_ready) written to tap k; w_out updates only
//     on LOAD exit (all TAPS slices together), stable at all other times.
//   stall = out_valid & ~out_ready.
//   RUN: in_ready = ~stall; arr_en = in_valid & ~stall; arr_x = in_data.
//   FLUSH: in_ready = 0; arr_en = ~stall while drain count < LAT; arr_x = 0.
//   vpipe[LAT-1:0]: tag shift register, shifts only when arr_en; bit0 <= 1 for an
//     accepted RUN sample, 0 for a flush advance.
//   Output: on a cycle with arr_en & vpipe[LAT-1], out_data <= arr_y, out_valid <= 1
//     (registered, visible next cycle). Else out_valid cleared when out_ready.
//     A capture and an out_ready handshake in the same cycle: new value replaces old.
//   Latency: with no stalls, result for sample n appears on out_valid at the cycle
//     after the LAT-th advance counted from (and including) sample n's acceptance.
//   No output drops: array never advances while stall=1.
//   flush in same cycle as an accepted sample: sample is accepted, then FLUSH.
//   cfg_start outside IDLE, flush outside RUN: ignored. coef_valid outside LOAD: ignored.
//   rst mid-operation: immediate return to reset values; loaded coefficients lost.
//   Arithmetic is in the array; controller passes W-bit values unmodified.
// TESTING (TAPS=4, LAT=4, W=32)
//   Reset: rst pulse mid-RUN -> next edge state IDLE, out_valid=0, w_out=0, busy=0.
//   Load: cfg_start, beats 1,2,3,4 -> w_out = {4,3,2,1} (tap0=1) only after 4th beat; RUN.
//   Impulse: in 1,0,0,0 back-to-back, out_ready=1 -> out 1,2,3,4 (golden array model),
//     first out_valid 4 cycles after first acceptance, one per cycle.
//   Backpressure: out_ready=0 for 5 cycles in stream -> arr_en=0, in_ready=0 while
//     out_valid held; out_data unchanged; sequence resumes with no loss/dup.
//   Flush: 2 samples then flush -> 4 zero advances, both results delivered, then IDLE.
//   Ignored ctrl: cfg_start in RUN, flush in IDLE, coef_valid in RUN -> no state change.

Source files
------------

// File: rtl/fir_array_ctrl.sv
// Sequencer for a TAPS-stage systolic FIR array: serial coefficient load, sample
// streaming with valid/ready, array advance enable, result tagging and a one-entry output.
module fir_array_ctrl #(
    parameter int W    = 32,
    parameter int TAPS = 4,
    parameter int LAT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [W-1:0]       coef_in,
    input  logic               coef_valid,
    output logic               coef_ready,
    output logic [TAPS*W-1:0]  w_out,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [W-1:0]       arr_x,
    output logic               arr_en,
    input  logic [W-1:0]       arr_y,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    // Handshakes: a beat/sample/result transfers on a cycle where valid & ready are both high;
    // valid never depends on ready, and out_valid stays asserted with stable data until taken.
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH} state_t;

    localparam int BW = $clog2(TAPS);
    localparam int DW = $clog2(LAT + 1);

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [TAPS*W-1:0] coef_q, coef_d;
    logic [TAPS*W-1:0] w_out_q, w_out_d;
    logic [LAT-1:0]    vpipe_q, vpipe_d;
    logic [LAT:0]      vpipe_ext;
    logic              vpipe_unused;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              stall, coef_fire, last_beat, drain_done, capture, tag;

    assign stall      = out_valid_q & ~out_ready;
    assign coef_fire  = coef_valid & coef_ready;
    assign last_beat  = coef_fire && (beat_cnt_q == BW'(TAPS - 1));
    assign drain_done = (drain_cnt_q == DW'(LAT));

    // Tag arriving at position LAT-1 on this advance marks the result now on arr_y.
    assign vpipe_ext    = {vpipe_q, tag};
    assign vpipe_unused = vpipe_ext[LAT];
    assign capture      = arr_en & vpipe_ext[LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cfg_start) state_d = S_LOAD;
            S_LOAD:  if (last_beat) state_d = S_RUN;
            S_RUN:   if (flush) state_d = S_FLUSH;
            S_FLUSH: if (drain_done && !out_valid_q) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        coef_ready = 1'b0;
        in_ready   = 1'b0;
        arr_en     = 1'b0;
        arr_x      = '0;
        tag        = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_LOAD: coef_ready = 1'b1;
            S_RUN: begin
                in_ready = ~stall;
                arr_en   = in_valid & ~stall;
                arr_x    = in_data;
                tag      = 1'b1;
            end
            S_FLUSH: arr_en = ~stall & ~drain_done;
        endcase
    end

    always_comb begin
        coef_d      = coef_q;
        beat_cnt_d  = beat_cnt_q;
        w_out_d     = w_out_q;
        drain_cnt_d = drain_cnt_q;
        vpipe_d     = vpipe_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (coef_fire) begin
            coef_d[int'(beat_cnt_q) * W +: W] = coef_in;
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BW'(1);
        end
        // The coefficient bus switches as a whole so the array never sees a half-loaded set.
        if (last_beat) w_out_d = coef_d;
        if (state_q == S_RUN && flush)            drain_cnt_d = '0;
        else if (state_q == S_FLUSH && arr_en)    drain_cnt_d = drain_cnt_q + DW'(1);
        if (arr_en) vpipe_d = vpipe_ext[LAT-1:0];
        if (capture) begin
            out_data_d  = arr_y;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_q      <= '0;
            beat_cnt_q  <= '0;
            w_out_q     <= '0;
            drain_cnt_q <= '0;
            vpipe_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            coef_q      <= coef_d;
            beat_cnt_q  <= beat_cnt_d;
            w_out_q     <= w_out_d;
            drain_cnt_q <= drain_cnt_d;
            vpipe_q     <= vpipe_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign w_out     = w_out_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule
